// File: rtl/sdl_jump_walker_if.sv
// rtl/sdl_jump_walker_if.sv - request/result bundle for the down-left jump walker
//   start/pieces/opp/empty : request side, driven by the master
//   busy/done              : status, driven by the walker
//   moves/reach/capt/hops  : results, valid from the done pulse until the next accepted start
interface sdl_jump_walker_if;
  logic        start;
  logic [31:0] pieces;
  logic [31:0] opp;
  logic [31:0] empty;
  logic        busy;
  logic        done;
  logic [31:0] moves;
  logic [31:0] reach;
  logic [31:0] capt;
  logic [1:0]  hops;

  modport master (
    output start, pieces, opp, empty,
    input  busy, done, moves, reach, capt, hops
  );

  modport slave (
    input  start, pieces, opp, empty,
    output busy, done, moves, reach, capt, hops
  );
endinterface

// File: rtl/sdl_jump_walker.sv
// rtl/sdl_jump_walker.sv - multi-cycle down-left move/jump explorer for checkers
//   i_clock : rising-edge clock
//   i_reset : asynchronous active-high reset
//   bus     : slave side of sdl_jump_walker_if (request masks in, status and result masks out)
module sdl_jump_walker #(
  parameter int MAX_HOPS = 3
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  sdl_jump_walker_if.slave     bus
);

  localparam logic [2:0] LP_MAX_HOPS = 3'(MAX_HOPS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_front;
  logic [31:0] r_opp;
  logic [31:0] r_empty;
  logic [31:0] r_moves;
  logic [31:0] r_reach;
  logic [31:0] r_capt;
  logic [1:0]  r_hops;

  logic [31:0] w_mid;
  logic [31:0] w_land;
  logic [31:0] w_capt;
  logic [2:0]  w_hops_inc;
  logic        w_stop;

  // Down-left shift: even rows move +3 except column 0, odd rows move +4, row 7 falls off.
  function automatic logic [31:0] sdl0(input logic [31:0] x);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 28; i++) begin
      if (((i >> 2) & 1) == 0) begin
        if ((i & 3) != 0) r[i + 3] = x[i];
      end else begin
        r[i + 4] = x[i];
      end
    end
    return r;
  endfunction

  // Exact inverse of sdl0: odd-row squares in columns 0..2 came from +3, even rows from +4.
  function automatic logic [31:0] sur0(input logic [31:0] x);
    logic [31:0] r;
    r = '0;
    for (int j = 4; j < 32; j++) begin
      if (((j >> 2) & 1) == 1) begin
        if ((j & 3) != 3) r[j - 3] = x[j];
      end else begin
        r[j - 4] = x[j];
      end
    end
    return r;
  endfunction

  // One jump iteration: step onto an opponent, then onto an empty square beyond it.
  // Captures are only the opponents that actually sit under a landing.
  assign w_mid      = sdl0(r_front) & r_opp;
  assign w_land     = sdl0(w_mid) & r_empty;
  assign w_capt     = w_mid & sur0(w_land);
  assign w_hops_inc = {1'b0, r_hops} + 3'd1;
  assign w_stop     = (w_land == '0) || (w_hops_inc == LP_MAX_HOPS);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_STEP;
      S_STEP:  if (w_stop)    w_state_nxt = S_DONE;
      S_DONE:                 w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_front <= '0;
      r_opp   <= '0;
      r_empty <= '0;
      r_moves <= '0;
      r_reach <= '0;
      r_capt  <= '0;
      r_hops  <= '0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_front <= bus.pieces;
      r_opp   <= bus.opp;
      r_empty <= bus.empty;
      r_moves <= sdl0(bus.pieces) & bus.empty;
      r_reach <= '0;
      r_capt  <= '0;
      r_hops  <= '0;
    end else if (r_state == S_STEP && w_land != '0) begin
      r_front <= w_land;
      r_reach <= r_reach | w_land;
      r_capt  <= r_capt | w_capt;
      r_hops  <= w_hops_inc[1:0];
    end
  end

  assign bus.busy  = (r_state == S_STEP) || (r_state == S_DONE);
  assign bus.done  = (r_state == S_DONE);
  assign bus.moves = r_moves;
  assign bus.reach = r_reach;
  assign bus.capt  = r_capt;
  assign bus.hops  = r_hops;

endmodule
